// File: rtl/core_skid_buffer_if.sv
// Ready/valid handshake bundle around core_skid_buffer: upstream in_* and downstream out_*.
// Signal suffixes are from the buffer's point of view (slave modport).
interface core_skid_buffer_if #(
    parameter int unsigned Bits = 8
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [Bits-1:0] in_data_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [Bits-1:0] out_data_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );

    // Environment side: drives the producer inputs and the consumer ready.
    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/core_skid_buffer.sv
// Registered ready/valid stage with a one-entry skid register; full throughput, no comb ready path.
// Optional saturating stall counter is enabled by defining CORE_SKID_BUFFER_STATS_EN.
module core_skid_buffer #(
    parameter int unsigned     Bits       = 8,
    parameter logic [Bits-1:0] ResetValue = {Bits{1'b0}}
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
`ifdef CORE_SKID_BUFFER_STATS_EN
    output logic [31:0]         stall_count_o,
`endif
    core_skid_buffer_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e          state_d, state_q;
    logic [Bits-1:0] main_d, main_q;
    logic [Bits-1:0] skid_d, skid_q;
    logic            in_ready, out_valid;
    logic            in_fire, out_fire;

    // Handshake outputs depend on registered state only.
    assign in_ready        = (state_q != FULL);
    assign out_valid       = (state_q != EMPTY);
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = main_q;

    assign in_fire  = bus.in_valid_i && in_ready;
    assign out_fire = out_valid && bus.out_ready_i;

    // NOTE: every path assigns defaults first so the next-state logic never infers a latch.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
            main_d  = ResetValue;
            skid_d  = ResetValue;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = bus.in_data_i;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data_i;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = bus.in_data_i;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments; the data registers are reset
    // too because ResetValue is architecturally visible on out_data_o.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            main_q  <= ResetValue;
            skid_q  <= ResetValue;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef CORE_SKID_BUFFER_STATS_EN
    logic [31:0] stall_count_d, stall_count_q;

    // Counts cycles where the head is offered but refused; flush leaves it alone.
    always_comb begin
        stall_count_d = stall_count_q;
        if (out_valid && !bus.out_ready_i && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count_o = stall_count_q;
`else
    // Statistics disabled: only the datapath above is built.
`endif

endmodule

// File: doc/core_skid_buffer.md
# core_skid_buffer

Registered ready/valid pipeline stage with a one-entry skid register. It sits directly upstream of the enable-gated data registers in the core pipelines: `out_valid_o && out_ready_i` acts as the downstream register's enable, and `out_data_o` is its data. Both the forward path (valid/data) and the backward path (ready) are registered, which breaks long timing paths between pipeline stages. It sustains full throughput of one transfer per cycle.

## Interface
- `Bits`, default 8: data width in bits; must be ≥ 1.
- `ResetValue`, default `{Bits{1'b0}}`: value loaded into the main and skid registers on reset and on flush.
- `clk_i`  in  1  single clock; all logic is rising-edge.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `flush_i`  in  1  synchronous clear of all held data; active-high.
- `in_valid_i`  in  1  upstream data valid.
- `in_ready_o`  out  1  stage can accept data; registered-state only.
- `in_data_i`  in  Bits  upstream data.
- `out_valid_o`  out  1  `out_data_o` is valid.
- `out_ready_i`  in  1  downstream accepts data.
- `out_data_o`  out  Bits  head data, driven from the main register.
- `stall_count_o`  out  32  saturating stall counter; present only with `CORE_SKID_BUFFER_STATS_EN`.

## Operation
- Transfer definitions:
  - Input fire: `in_fire = in_valid_i && in_ready_o`.
  - Output fire: `out_fire = out_valid_o && out_ready_i`.
- Storage: main register (head), skid register, and a 2-bit state.
- States:
  - EMPTY: no data held.
  - BUSY: main register holds data, skid register unused.
  - FULL: both registers hold data.
- Outputs decoded from state only:
  - `out_valid_o = (state != EMPTY)`.
  - `in_ready_o = (state != FULL)`.
  - There is no combinational path from `out_ready_i` to `in_ready_o`.
- Transitions:
  - EMPTY, in_fire → BUSY; main ← `in_data_i`.
  - BUSY, in_fire and out_fire → BUSY; main ← `in_data_i`.
  - BUSY, in_fire only → FULL; skid ← `in_data_i`.
  - BUSY, out_fire only → EMPTY.
  - FULL, out_fire → BUSY; main ← skid. No input can fire while FULL.
  - Any other combination holds state and registers.
- Ordering: strict FIFO. Data leaves in acceptance order, with no drops and no duplication.
- Flush: when `flush_i`=1, the next state is EMPTY and main/skid ← `ResetValue`.
  - A same-cycle in_fire is discarded.
  - A same-cycle out_fire is still a valid transfer, because the downstream sampled it.
- Reset: when `rst_ni`=0 at an edge, state ← EMPTY and main/skid ← `ResetValue`; all inputs are ignored.
  - Reset beats flush.
  - Reset mid-transfer loses held data; this is the required behaviour.
- Reset values after the reset edge: `out_valid_o`=0, `in_ready_o`=1, `out_data_o`=`ResetValue`, `stall_count_o`=0.

## Timing
- Latency: one cycle. Data accepted at edge N is on `out_data_o` with `out_valid_o`=1 after edge N.
- Throughput: one transfer per cycle when `out_ready_i` is held high.
- Backpressure: `in_ready_o` deasserts one cycle after the first stalled accept (BUSY→FULL). The skid register absorbs the word that arrives in that cycle.
- Stability: while `out_valid_o && !out_ready_i`, `out_data_o` and `out_valid_o` hold unchanged, except on flush or reset.
- `in_ready_o` reasserts the cycle after an out_fire in FULL.

## Configuration
- Macro: `CORE_SKID_BUFFER_STATS_EN`.
- When defined:
  - `stall_count_o` exists.
  - It increments by 1 on each cycle with `out_valid_o && !out_ready_i`.
  - It saturates at 32'hFFFF_FFFF.
  - Reset clears it; flush does not.
- When undefined: the port and the counter logic are absent. Datapath behaviour is identical.

## Test plan
All scenarios use `Bits`=8 and `ResetValue`=8'hA5.
- Reset: hold `rst_ni`=0 for 2 cycles with `in_valid_i`=1, `in_data_i`=8'h11 → after release, `out_valid_o`=0, `in_ready_o`=1, `out_data_o`=8'hA5, and nothing is accepted.
- Streaming: drive 8'h01..8'h10 on consecutive cycles with `out_ready_i`=1 → outputs 8'h01..8'h10 in order, one per cycle, first output one cycle after the first accept, and `in_ready_o` stays 1.
- Skid: accept 8'h20, then drop `out_ready_i` while 8'h21 and 8'h22 are offered → 8'h21 is accepted into the skid register, `in_ready_o`=0 next cycle, and 8'h22 is held upstream. Raise `out_ready_i` → output sequence is 8'h20, 8'h21, 8'h22 with no loss.
- Flush: in FULL holding 8'h30/8'h31, pulse `flush_i` with `in_valid_i`=1, `in_data_i`=8'h32 → next cycle EMPTY, `out_data_o`=8'hA5, and 8'h32 never appears at the output.
- Random: randomized `in_valid_i`/`out_ready_i` at 50% for 10,000 cycles against a scoreboard → identical ordered stream, and `out_data_o` never changes during a stall.
- Stats (macro defined): stall 5 cycles, then fire → `stall_count_o`=5; a flush leaves it at 5; a reset sets it to 0.
